// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative 32-bit multiply / divide unit with HI/LO result registers.
// An operation takes 33 cycles from the accepting edge to the result:
//   - 32 cycles in CALC, one shift-add or restoring-divide step per cycle.
//   - 1 cycle in FIX, which applies the result signs and writes hi/lo.
// Signed operations work on operand magnitudes. The signs are applied in FIX.
//
// Ports
//   clk         in   1  clock, rising edge
//   reset       in   1  synchronous, active-low reset
//   start       in   1  start a new operation (accepted only in IDLE)
//   op          in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   in  32  multiplicand / dividend
//   operand_b   in  32  multiplier / divisor
//   cancel      in   1  abort the operation in flight; blocks start in IDLE
//   write_hi    in   1  MTHI: load hi from write_data (IDLE only)
//   write_lo    in   1  MTLO: load lo from write_data (IDLE only)
//   write_data  in  32  MTHI/MTLO data
//   busy        out  1  operation in flight (CALC or FIX)
//   done        out  1  one-cycle pulse after hi/lo receive a new result
//   hi          out 32  product upper word / remainder
//   lo          out 32  product lower word / quotient
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        cancel,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg;
  logic        is_div_reg;
  logic        neg_q_reg;     // product sign, or quotient sign
  logic        neg_r_reg;     // remainder sign (the sign of the dividend)
  logic        div_zero_reg;
  logic [31:0] a_raw_reg;     // unsigned dividend pattern, returned on divide by zero
  logic [31:0] opnd_reg;      // multiplicand magnitude, or divisor magnitude
  logic [63:0] acc_reg;       // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] hi_reg, lo_reg;
  logic        done_reg;

  // ---------------------------------------------------------------------------
  // Operand decode at the accepting edge
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        op_signed;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;

  assign accept    = (state_reg == IDLE) && start && !cancel;
  assign op_signed = ~op[0];
  assign sign_a    = op_signed & operand_a[31];
  assign sign_b    = op_signed & operand_b[31];
  // The magnitude of 0x80000000 is 0x80000000 when read as unsigned, which is
  // exactly what the unsigned datapath needs.
  assign mag_a     = sign_a ? (32'd0 - operand_a) : operand_a;
  assign mag_b     = sign_b ? (32'd0 - operand_b) : operand_b;

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [32:0] mult_sum;
  logic [63:0] mult_step;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_trial;
  logic [63:0] div_step;

  // Shift-add: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the 65-bit {carry, acc} right by one.
  assign mult_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign mult_step = {mult_sum, acc_reg[31:1]};

  // Restoring division: shift the next dividend bit into the remainder.
  // When the shifted remainder is at least the divisor, subtract and set the
  // quotient bit. The difference always fits in 32 bits in that case.
  assign div_shift = {acc_reg[63:32], acc_reg[31]};
  assign div_ge    = (div_shift >= {1'b0, opnd_reg});
  assign div_trial = div_shift[31:0] - opnd_reg;
  assign div_step  = div_ge ? {div_trial, acc_reg[30:0], 1'b1}
                            : {div_shift[31:0], acc_reg[30:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Final sign fix-up
  // ---------------------------------------------------------------------------
  logic [63:0] prod_fixed;
  logic [31:0] quot_fixed, rem_fixed;
  logic [31:0] res_hi, res_lo;

  assign prod_fixed = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
  assign quot_fixed = neg_q_reg ? (32'd0 - acc_reg[31:0]) : acc_reg[31:0];
  assign rem_fixed  = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];

  always_comb begin
    res_hi = prod_fixed[63:32];
    res_lo = prod_fixed[31:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        res_hi = a_raw_reg;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = rem_fixed;
        res_lo = quot_fixed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic fix_write;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fix_write  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !cancel) begin
          state_next = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_next = IDLE;
        end else if (cnt_reg == 5'd31) begin
          state_next = FIX;
        end
      end
      FIX: begin
        // The FSM always returns to IDLE; cancel only blocks the write.
        state_next = IDLE;
        fix_write  = !cancel;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg      <= 5'd0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      a_raw_reg    <= 32'd0;
      opnd_reg     <= 32'd0;
      acc_reg      <= 64'd0;
    end else if (accept) begin
      cnt_reg      <= 5'd0;
      is_div_reg   <= op[1];
      neg_q_reg    <= sign_a ^ sign_b;
      neg_r_reg    <= sign_a;
      div_zero_reg <= op[1] && (operand_b == 32'd0);
      a_raw_reg    <= operand_a;
      opnd_reg     <= op[1] ? mag_b : mag_a;
      acc_reg      <= op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
    end else if (state_reg == CALC && !cancel) begin
      cnt_reg <= cnt_reg + 5'd1;
      acc_reg <= is_div_reg ? div_step : mult_step;
    end
  end

  // hi/lo: results from FIX; MTHI/MTLO only while IDLE. A start in the same
  // IDLE cycle as an MT write is also accepted, and the later result overwrites
  // the MT value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_reg   <= 32'd0;
      lo_reg   <= 32'd0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= fix_write;
      if (fix_write) begin
        hi_reg <= res_hi;
        lo_reg <= res_lo;
      end else if (state_reg == IDLE) begin
        if (write_hi) begin
          hi_reg <= write_data;
        end
        if (write_lo) begin
          lo_reg <= write_data;
        end
      end
    end
  end

  assign busy = (state_reg == CALC) || (state_reg == FIX);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        cancel = 1'b0;
  logic        write_hi = 1'b0;
  logic        write_lo = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .cancel(cancel),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: {hi, lo} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin
        p = 64'(sa * sb);
        return p;
      end
      2'd1: begin
        p = 64'(a) * 64'(b);
        return p;
      end
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Drives start for one edge, then scrambles the operand bus.
  task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic wl, input logic [31:0] wd);
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    write_lo = wl; write_data = wd;
    @(negedge clk);
    start = 1'b0; write_lo = 1'b0;
    op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
  endtask

  // Counts busy cycles, then checks the result and the done pulse.
  // disturb: pulse start + MTHI/MTLO at busy cycle 5; all of it must be ignored.
  task automatic finish_op(input string tag, input logic [63:0] expv, input bit disturb);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
        write_hi = 1'b1; write_lo = 1'b1; write_data = $urandom;
      end else begin
        start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    exp_hi = expv[63:32];
    exp_lo = expv[31:0];
    chk({tag, "_busy_len"}, 32'(n), 32'd33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    $display("txn %s: hi=%h lo=%h busy_cycles=%0d", tag, hi, lo, n);
    @(negedge clk);
    chk({tag, "_done_end"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input bit disturb);
    do_start(o, a, b, 1'b0, 32'd0);
    finish_op(tag, model(o, a, b), disturb);
  endtask

  initial begin
    int dcount;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;

    // MTHI alone, then MTHI+MTLO together
    @(negedge clk); write_hi = 1'b1; write_data = 32'h0000_A5A5;
    @(negedge clk); write_hi = 1'b0;
    chk("mthi_hi", hi, 32'h0000_A5A5);
    chk("mthi_lo", lo, 32'd0);
    $display("txn mthi: hi=%h lo=%h", hi, lo);
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'h5A5A_0F0F;
    @(negedge clk); write_hi = 1'b0; write_lo = 1'b0;
    chk("mtboth_hi", hi, 32'h5A5A_0F0F);
    chk("mtboth_lo", lo, 32'h5A5A_0F0F);
    $display("txn mthi+mtlo: hi=%h lo=%h", hi, lo);

    // Directed cases, with the expected values stated literally
    do_start(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'd0);
    finish_op("mult_m3x5", {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b0);
    do_start(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0);
    finish_op("multu_max", {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
    do_start(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0);
    finish_op("div_m7d2", {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    do_start(2'd3, 32'd100, 32'd0, 1'b0, 32'd0);
    finish_op("divu_by0", {32'h0000_0064, 32'hFFFF_FFFF}, 1'b0);
    do_start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0);
    finish_op("div_ovf", {32'h0000_0000, 32'h8000_0000}, 1'b0);
    run_op("div_by0_neg", 2'd2, 32'h8000_0007, 32'd0, 1'b0);

    // Randomized operations against the reference model
    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 1) rb = 32'($urandom_range(0, 9));
      if (i % 4 == 2) rb = rb | 32'h8000_0000;
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'b0);
    end

    // Start and MT writes while busy are ignored
    run_op("ignore_start", 2'd1, 32'h0001_2345, 32'h0000_6789, 1'b1);
    run_op("ignore_start_div", 2'd2, 32'hF000_0001, 32'h0000_0013, 1'b1);

    // start + MTLO together in IDLE: the result overwrites lo
    do_start(2'd3, 32'd1000, 32'd7, 1'b1, 32'hDEAD_BEEF);
    chk("st_mtlo_lo_early", lo, 32'hDEAD_BEEF);
    finish_op("st_mtlo", model(2'd3, 32'd1000, 32'd7), 1'b0);

    // MTHI 0x1234, MULTU 6*7, cancel at busy cycle 10
    @(negedge clk); write_hi = 1'b1; write_data = 32'h0000_1234;
    @(negedge clk); write_hi = 1'b0;
    exp_hi = 32'h0000_1234;
    do_start(2'd1, 32'd6, 32'd7, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, exp_hi);
    chk("cancel_lo", lo, exp_lo);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("cancel_no_done", 32'(dcount), 32'd0);
    chk("cancel_hi_late", hi, exp_hi);
    $display("txn cancel: hi=%h lo=%h done_pulses=%0d", hi, lo, dcount);

    // cancel together with start in IDLE suppresses the start
    @(negedge clk);
    op = 2'd1; operand_a = 32'd3; operand_b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    chk("idle_cancel_busy", {31'd0, busy}, 32'd0);
    dcount = 0;
    repeat (36) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("idle_cancel_no_done", 32'(dcount), 32'd0);
    chk("idle_cancel_lo", lo, exp_lo);
    $display("txn start+cancel: busy=%0d hi=%h lo=%h", busy, hi, lo);

    // Reset at busy cycle 20 of a DIV
    do_start(2'd2, 32'h7654_3210, 32'h0000_0123, 1'b0, 32'd0);
    repeat (19) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    $display("txn reset_mid_div: busy=%0d hi=%h lo=%h", busy, hi, lo);

    // The unit still works after the mid-operation reset
    run_op("post_rst", 2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
